// File: rtl/mdu_ctrl_pkg.sv
// mdu_pkg: shared types and constants for the HI/LO multiply/divide unit.
//   mdu_op_e    - op codes driven by the execute stage (6-7 reserved)
//   mdu_state_e - sequencer states
//   MDU_WIDTH   - default operand / HI / LO width
//   MDU_LATENCY - busy cycles for a full mult/div (ITER + FIX)
package mdu_pkg;

    localparam int unsigned MDU_WIDTH   = 32;
    localparam int unsigned MDU_LATENCY = MDU_WIDTH + 1;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: execute-stage <-> multiply/divide unit bundle.
//   master: pipeline side (drives start/op/a/b/flush, sees busy/done/hi/lo)
//   slave : the mdu_ctrl block
// Optional macro MDU_DIVZERO_EN adds the divz pulse output.
interface mdu_ctrl_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MDU_DIVZERO_EN
    logic             divz;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo, divz);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo, divz);
`else
    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
`endif
endinterface

// File: rtl/mdu_ctrl_addsub.sv
// mdu_addsub: (WIDTH+1)-bit adder/subtractor shared by the multiply and divide
// iterations.
//   i_a, i_b : operands
//   i_sub    : 1 = i_a - i_b, 0 = i_a + i_b
//   o_sum    : result
//   o_cout   : carry out (add) / not-borrow (sub)
module mdu_addsub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_b,
    input  logic           i_sub,
    output logic [WIDTH:0] o_sum,
    output logic           o_cout
);
    logic [WIDTH+1:0] w_full;

    // Subtract as a + ~b + 1 so carry out means "no borrow".
    assign w_full = {1'b0, i_a} + {1'b0, (i_sub ? ~i_b : i_b)}
                  + {{(WIDTH+1){1'b0}}, i_sub};
    assign o_sum  = w_full[WIDTH:0];
    assign o_cout = w_full[WIDTH+1];
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer owning the HI/LO registers.
//   i_clk   : rising-edge clock
//   i_reset : synchronous active-low reset
//   bus     : mdu_ctrl_if.slave (start/op/a/b/flush in; busy/done/hi/lo out)
// Optional macro MDU_DIVZERO_EN: divide-by-zero short-cut straight to FIX with
// hi=a, lo=all ones, plus a divz pulse alongside done.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    mdu_ctrl_if.slave   bus
);
    localparam logic [WIDTH-1:0]   ONE_W  = 1;
    localparam logic [2*WIDTH-1:0] ONE_2W = 1;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + ONE_W) : v;
    endfunction

    mdu_state_e         r_state, w_state_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic [2*WIDTH-1:0] r_acc, w_acc_d;   // {upper, lower} = {product hi, multiplier} / {rem, quot}
    logic [WIDTH-1:0]   r_opb, w_opb_d;   // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   r_hi, w_hi_d;
    logic [WIDTH-1:0]   r_lo, w_lo_d;
    logic               r_div, w_div_d;
    logic               r_sa, w_sa_d;
    logic               r_sb, w_sb_d;
    logic               r_done, w_done_d;
`ifdef MDU_DIVZERO_EN
    logic               r_dz, w_dz_d;     // current op is a divide by zero
    logic               r_divz, w_divz_d;
`endif

    mdu_op_e            w_op;
    logic               w_op_sgn, w_op_div;
    logic [WIDTH:0]     w_as_a, w_as_b, w_as_sum;
    logic               w_as_cout;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_op     = mdu_op_e'(bus.op);
    assign w_op_sgn = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_op_div = (w_op == OP_DIV)  || (w_op == OP_DIVU);

    // Multiply adds into the upper half; divide trial-subtracts from the
    // left-shifted remainder (upper half plus the next quotient bit).
    assign w_as_a = r_div ? r_acc[2*WIDTH-1:WIDTH-1] : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_as_b = {1'b0, r_opb};

    mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_a    (w_as_a),
        .i_b    (w_as_b),
        .i_sub  (r_div),
        .o_sum  (w_as_sum),
        .o_cout (w_as_cout)
    );

    assign w_prod_neg = ~r_acc + ONE_2W;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_acc_d   = r_acc;
        w_opb_d   = r_opb;
        w_hi_d    = r_hi;
        w_lo_d    = r_lo;
        w_div_d   = r_div;
        w_sa_d    = r_sa;
        w_sb_d    = r_sb;
        w_done_d  = 1'b0;
`ifdef MDU_DIVZERO_EN
        w_dz_d    = r_dz;
        w_divz_d  = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (w_op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            w_div_d   = w_op_div;
                            w_sa_d    = w_op_sgn & bus.a[WIDTH-1];
                            w_sb_d    = w_op_sgn & bus.b[WIDTH-1];
                            w_opb_d   = f_neg(bus.b, w_op_sgn & bus.b[WIDTH-1]);
                            w_acc_d   = {{WIDTH{1'b0}}, f_neg(bus.a, w_op_sgn & bus.a[WIDTH-1])};
                            w_cnt_d   = '0;
                            w_state_d = S_ITER;
`ifdef MDU_DIVZERO_EN
                            w_dz_d = w_op_div && (bus.b == '0);
                            if (w_op_div && (bus.b == '0)) begin
                                w_acc_d   = {bus.a, {WIDTH{1'b1}}};
                                w_state_d = S_FIX;
                            end
`endif
                        end
                        OP_MTHI: w_hi_d = bus.a;
                        OP_MTLO: w_lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            S_ITER: begin
                if (bus.flush) begin
                    w_state_d = S_IDLE;
                end else begin
                    if (!r_div) begin
                        // Keep the adder carry as the new MSB before shifting right.
                        w_acc_d = r_acc[0] ? {w_as_sum, r_acc[WIDTH-1:1]}
                                           : {1'b0, r_acc[2*WIDTH-1:1]};
                    end else begin
                        w_acc_d = w_as_cout ? {w_as_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                            : {r_acc[2*WIDTH-2:0], 1'b0};
                    end
                    w_cnt_d = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                w_state_d = S_IDLE;
                if (!bus.flush) begin
                    w_done_d = 1'b1;
                    if (r_div) begin
                        w_hi_d = f_neg(r_acc[2*WIDTH-1:WIDTH], r_sa);
                        w_lo_d = f_neg(r_acc[WIDTH-1:0], r_sa ^ r_sb);
                    end else begin
                        {w_hi_d, w_lo_d} = (r_sa ^ r_sb) ? w_prod_neg : r_acc;
                    end
`ifdef MDU_DIVZERO_EN
                    if (r_dz) begin
                        {w_hi_d, w_lo_d} = r_acc;
                        w_divz_d         = 1'b1;
                    end
`endif
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opb   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_done  <= 1'b0;
`ifdef MDU_DIVZERO_EN
            r_dz    <= 1'b0;
            r_divz  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_acc   <= w_acc_d;
            r_opb   <= w_opb_d;
            r_hi    <= w_hi_d;
            r_lo    <= w_lo_d;
            r_div   <= w_div_d;
            r_sa    <= w_sa_d;
            r_sb    <= w_sb_d;
            r_done  <= w_done_d;
`ifdef MDU_DIVZERO_EN
            r_dz    <= w_dz_d;
            r_divz  <= w_divz_d;
`endif
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
`ifdef MDU_DIVZERO_EN
    assign bus.divz = r_divz;
`endif
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl (one task per scenario).
// Honours MDU_DIVZERO_EN the same way as the design.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mdu_ctrl_if #(.WIDTH(32)) bus ();

    mdu_ctrl u_dut (
        .i_clk   (clk),
        .i_reset (reset_n),
        .bus     (bus)
    );

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts busy samples until done is seen (bounded); returns at the done sample.
    task automatic wait_done(output int busy_cyc, output bit got);
        busy_cyc = 0;
        got      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        reset_n = 1'b1;
    endtask

    task automatic test_mult();
        int n; bit got;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(n, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL mult_done: got %b want 1", got); end
        checks++; if (n != MDU_LATENCY) begin errors++; $display("FAIL mult_busy_cycles: got %0d want %0d", n, MDU_LATENCY); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done: got %b want 0", bus.busy); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h want fffffff1", bus.lo); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_multu();
        int n; bit got;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, got);
        checks++; if (got !== 1'b1 || n != MDU_LATENCY) begin errors++; $display("FAIL multu_timing: got done=%b busy=%0d want 1/%0d", got, n, MDU_LATENCY); end
        checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
        checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
    endtask

    task automatic test_div();
        int n; bit got;
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(n, got);
        checks++; if (got !== 1'b1 || n != MDU_LATENCY) begin errors++; $display("FAIL divu_timing: got done=%b busy=%0d want 1/%0d", got, n, MDU_LATENCY); end
        checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", bus.lo); end
        checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 00000002", bus.hi); end
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(n, got);
        checks++; if (got !== 1'b1 || n != MDU_LATENCY) begin errors++; $display("FAIL div_timing: got done=%b busy=%0d want 1/%0d", got, n, MDU_LATENCY); end
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", bus.hi); end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'h1234_5678;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mthi_lo: got %h want fffffffd", bus.lo); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mthi_flags: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
        bus.start = 1'b1; bus.op = OP_MTLO; bus.a = 32'hCAFE_F00D;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo_lo: got %h want cafef00d", bus.lo); end
        checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi: got %h want 12345678", bus.hi); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mtlo_flags: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
    endtask

    task automatic test_start_while_busy();
        int n = 0; int m; bit got;
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) begin
            if (bus.busy === 1'b1) n++;
            @(negedge clk);
        end
        if (bus.busy === 1'b1) n++;
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd5; bus.b = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(m, got);
        checks++; if (got !== 1'b1 || (n + m) != MDU_LATENCY) begin errors++; $display("FAIL busy_ignore_timing: got done=%b busy=%0d want 1/%0d", got, n + m, MDU_LATENCY); end
        checks++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin errors++; $display("FAIL busy_ignore_result: got hi=%h lo=%h want 00000002/0000000e", bus.hi, bus.lo); end
    endtask

    task automatic test_back_to_back();
        int n; bit got;
        issue(OP_MULTU, 32'd3, 32'd4);
        wait_done(n, got);
        checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd12) begin errors++; $display("FAIL b2b_first: got hi=%h lo=%h want 0/0000000c", bus.hi, bus.lo); end
        // New request in the done cycle must be accepted.
        bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'hFFFF_FFFE; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n, got);
        checks++; if (got !== 1'b1 || n != MDU_LATENCY) begin errors++; $display("FAIL b2b_timing: got done=%b busy=%0d want 1/%0d", got, n, MDU_LATENCY); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL b2b_second: got hi=%h lo=%h want ffffffff/fffffffa", bus.hi, bus.lo); end
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
        repeat (40) begin
            if (bus.done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b want 0", seen); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL flush_hilo: got hi=%h lo=%h want ffffffff/fffffffa", bus.hi, bus.lo); end
        // Flush together with start in IDLE: request dropped.
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_DIVU; bus.a = 32'd8; bus.b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle_start: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        issue(OP_DIVU, 32'd50, 32'd5);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL reset_mid_hilo: got hi=%h lo=%h want 0/0", bus.hi, bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_divzero();
        int n; bit got;
        issue(OP_DIVU, 32'd9, 32'd0);
        wait_done(n, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL divz_done: got %b want 1", got); end
`ifdef MDU_DIVZERO_EN
        checks++; if (n != 1) begin errors++; $display("FAIL divz_busy_cycles: got %0d want 1", n); end
        checks++; if (bus.divz !== 1'b1) begin errors++; $display("FAIL divz_pulse: got %b want 1", bus.divz); end
`else
        checks++; if (n != MDU_LATENCY) begin errors++; $display("FAIL divz_busy_cycles: got %0d want %0d", n, MDU_LATENCY); end
`endif
        checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h want ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'd9) begin errors++; $display("FAIL divz_hi: got %h want 00000009", bus.hi); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mthi_mtlo();
        test_start_while_busy();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_divzero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit and sequencer for the MIPS execute stage. It owns the architectural HI/LO registers.
- It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO ops from the pipeline and iterates one bit per cycle over a shared add/subtract datapath.
- While busy it raises a stall request to the hazard unit.
- The main ALU remains single-cycle. This block handles only the HI/LO class of instructions.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- CNT_W, $clog2(WIDTH), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  op request valid (execute stage).
- op  in  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
- a  in  WIDTH  rs operand (dividend / multiplicand / MT source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  pipeline flush; aborts an in-flight operation.
- busy  out  1  operation in progress; hazard unit stalls MFHI/MFLO and new HI/LO ops.
- done  out  1  one-cycle pulse when HI/LO are updated by a mult/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
  - Reset mid-operation discards the operation.
- States: IDLE, ITER, FIX.
- IDLE:
  - start=1 and op in 0..3 → latch operands, sign flags and op; state=ITER; counter=0.
  - Operands are stored as magnitudes for signed ops (two's-complement negate if MSB set).
  - start=1 and op=4 → hi<=a. op=5 → lo<=a. Both take effect next edge, no busy, no done.
  - Reserved ops are ignored.
- ITER (exactly WIDTH cycles; counter increments 0..WIDTH-1, then state=FIX):
  - Multiply: shift-add. If the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH accumulator, keeping the carry. Then shift right 1.
  - Divide: restoring. Shift {rem,quot} left 1. Trial-subtract the divisor from rem. If no borrow, keep the difference and set the quot LSB to 1.
- FIX (1 cycle), sign correction:
  - Product is negated if sa^sb (signed MULT only).
  - Quotient is negated if sa^sb; remainder takes the sign of a (signed DIV only).
  - At the FIX exit edge: {hi,lo}<=product, or hi<=remainder, lo<=quotient; done<=1; state=IDLE.
- Timing:
  - busy=1 for all of ITER and FIX: WIDTH+1 = 33 cycles after the accepting edge.
  - done is high in the cycle after FIX, concurrent with busy=0.
  - A new start is accepted in the done cycle.
- start while busy is ignored. The hazard unit guarantees it holds the instruction.
- flush while busy → state=IDLE at the next edge; hi/lo unchanged; no done.
- flush in IDLE with start → the op is not accepted (flush wins).
- Division by zero without the feature: runs the full 33 cycles with the algorithmic result. For DIVU: lo=all ones, hi=a.
- MULTU 0xFFFFFFFF*0xFFFFFFFF: the full 64-bit result is kept; the carry out of the accumulator add must not be dropped.

Optional Feature:
- Macro: MDU_DIVZERO_EN.
- Defined:
  - DIV/DIVU with b==0 is detected in IDLE and goes straight to FIX.
  - Result: hi=a, lo=all ones. busy lasts 1 cycle, then done.
  - Adds output port divz (1 bit), which pulses alongside done.
- Undefined: no divz port; divide-by-zero runs the normal 33-cycle path.

Decomposition:
- Package mdu_pkg:
  - typedef enum logic [2:0] for op codes (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO).
  - typedef enum for states (S_IDLE, S_ITER, S_FIX).
  - localparam MDU_LATENCY = WIDTH+1.
- Sub-module mdu_addsub: WIDTH+1-bit add/subtract with carry/borrow out, shared by the multiply and divide iterations.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 → after 33 busy cycles, done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU a=100, b=7 → lo=14, hi=2. Then DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI a=0x12345678 with busy=0 → next cycle hi=0x12345678, lo unchanged, busy/done never asserted. Start DIV then raise start again on cycle 10 → second request ignored, result from the first.
- DIV started, flush on cycle 5 → busy drops next cycle, hi/lo keep their previous values, no done. Reset asserted (0) mid-ITER → next cycle hi=lo=0, busy=0.
- DIVU a=9, b=0:
  - Without MDU_DIVZERO_EN → 33 busy cycles, lo=0xFFFFFFFF, hi=9.
  - With MDU_DIVZERO_EN → busy 1 cycle, done and divz pulse together, same hi/lo.
